// File: rtl/mips_md_pkg.sv
// ---------------------------------------------------------------------------
// mips_md_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     MD_WIDTH   - default operand / HI / LO width in bits
//     md_state_e - sequencer state encoding (IDLE -> RUN -> FIX -> IDLE)
// ---------------------------------------------------------------------------
package mips_md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// ---------------------------------------------------------------------------
// md_step
//   Combinational single-iteration datapath for the iterative mult/div unit.
//   The accumulator is 2*WIDTH+1 bits. Multiply and divide both start with
//   the unsigned operand magnitude in the low WIDTH bits.
//     multiply : shift-add, LSB first. If acc[0] is set, opnd is added into
//                the upper half (with carry), then the whole accumulator
//                shifts right by one.
//     divide   : restoring. The accumulator shifts left by one, then a trial
//                subtract of opnd is made from the upper WIDTH+1 bits. If the
//                subtract does not borrow, it is kept and quotient bit 1 is
//                shifted into bit 0.
//   Ports:
//     is_mult  in   1          1 = multiply step, 0 = divide step
//     acc      in   2*WIDTH+1  current accumulator
//     opnd     in   WIDTH      multiplicand / divisor magnitude
//     acc_next out  2*WIDTH+1  accumulator after one iteration
// ---------------------------------------------------------------------------
module md_step
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_mult,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) sum = sum + {1'b0, opnd};

    // The partial remainder is always below the divisor. After the shift it
    // therefore fits in WIDTH+1 bits. One extra bit on the subtract exposes
    // the borrow.
    shl  = acc << 1;
    diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, opnd};

    if (is_mult)
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    else if (diff[WIDTH+1])
      acc_next = shl;
    else
      acc_next = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
  end

endmodule

// File: rtl/iter_mult_div.sv
// ---------------------------------------------------------------------------
// iter_mult_div
//   MIPS-style iterative multiply/divide unit with HI/LO registers.
//   It processes one bit per cycle with a fixed latency. A start accepted at
//   edge t0 writes HI/LO at edge t0+WIDTH+1, and done pulses in the
//   following cycle.
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      synchronous active-high reset
//     start        in   1      request operation; accepted only while idle
//     is_mult      in   1      1 = multiply, 0 = divide (sampled with start)
//     is_unsigned  in   1      1 = unsigned, 0 = two's complement
//     a, b         in   WIDTH  multiplicand/dividend, multiplier/divisor
//     flush        in   1      abort the in-flight operation
//     wr_hi, wr_lo in   1      direct HI/LO write (MTHI/MTLO), idle only
//     wdata        in   WIDTH  data for wr_hi / wr_lo
//     busy         out  1      operation in flight
//     done         out  1      one-cycle pulse; HI/LO hold the new result
//     div_by_zero  out  1      pulses with done when the divisor was zero
//     hi, lo       out  WIDTH  HI/LO register contents
// ---------------------------------------------------------------------------
module iter_mult_div
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mult,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ACC_W = 2*WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc, acc_step;
  logic [WIDTH-1:0] opnd;
  logic             op_mult, neg_res, neg_rem, zero_div;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [WIDTH-1:0] quo, rem;
  logic [2*WIDTH-1:0] prod;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_mult  (op_mult),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  // NOTE: every variable in a combinational block is given a default first,
  // so that no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    a_neg = ~is_unsigned & a[WIDTH-1];
    b_neg = ~is_unsigned & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Sequencer next state. flush wins over normal progress in RUN.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (flush) state_next = S_IDLE;
               else if (cnt == CNT_W'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Sign correction of the finished magnitude result.
  // The divide-by-zero quotient is forced to all ones. The remainder is
  // already |a|, so re-applying a's sign returns a unchanged.
  always_comb begin
    prod   = acc[2*WIDTH-1:0];
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    fix_hi = '0;
    fix_lo = '0;
    if (op_mult) begin
      if (neg_res) prod = -prod;
      {fix_hi, fix_lo} = prod;
    end else begin
      fix_lo = zero_div ? '1 : (neg_res ? -quo : quo);
      fix_hi = neg_rem ? -rem : rem;
    end
  end

  // Control counter, HI/LO and the status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          if (start) cnt  <= CNT_W'(WIDTH);
        end
        S_RUN: begin
          if (!flush) cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            dz_q   <= zero_div;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the datapath registers carry no reset. Every operation reloads
  // them at start, and nothing observes them while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      acc      <= {(WIDTH+1)'(0), a_mag};
      opnd     <= b_mag;
      op_mult  <= is_mult;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      zero_div <= ~is_mult & (b == '0);
    end else if (state == S_RUN) begin
      acc <= acc_step;
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_iter_mult_div.sv
// ---------------------------------------------------------------------------
// tb_iter_mult_div
//   Self-checking bench for iter_mult_div (WIDTH=32): directed corner cases,
//   mid-operation start/flush/reset/write events, back-to-back operations and
//   randomized operations against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_iter_mult_div;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, start, is_mult, is_unsigned, flush, wr_hi, wr_lo;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int vectors     = 0;
  int miscompares = 0;

  iter_mult_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_mult     (is_mult),
    .is_unsigned (is_unsigned),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {HI, LO} computed with native integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic m, input logic u,
                                           input logic [W-1:0] x, input logic [W-1:0] y,
                                           output logic dz);
    int          sx, sy, q, r;
    longint      sp;
    logic [63:0] ux, uy;
    dz = 1'b0;
    sx = x;
    sy = y;
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (m) begin
      if (u) return ux * uy;
      sp = longint'(sx) * longint'(sy);
      return sp;
    end
    if (y == 0) begin
      dz = 1'b1;
      return {x, 32'hFFFF_FFFF};
    end
    if (u) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = sx / sy;
    r = sx % sy;
    return {r, q};
  endfunction

  // Runs one operation. Edge 0 is the start edge. ev_kind is applied on
  // edge ev_at: 1 = extra start, 2 = flush, 3 = rst, 4 = wr_hi+wr_lo.
  task automatic run_op(input logic m, input logic u, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input int ev_kind, input int ev_at, input logic stop_at_done,
                        output int done_at, output int done_cnt, output int busy_cnt,
                        output logic dz_at_done, output int stray_dz,
                        output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                        output logic ev_busy, output logic [W-1:0] ev_hi, output logic [W-1:0] ev_lo);
    done_at = 0; done_cnt = 0; busy_cnt = 0; stray_dz = 0;
    dz_at_done = 1'b0; ev_busy = 1'b1; ev_hi = '0; ev_lo = '0;
    rhi = '0; rlo = '0;
    for (int n = 0; n <= LAT + 3; n++) begin
      if (n == 0) begin
        start = 1'b1; is_mult = m; is_unsigned = u; a = oa; b = ob;
      end
      if (n == ev_at) begin
        case (ev_kind)
          1: begin start = 1'b1; is_mult = 1'b1; is_unsigned = 1'b1; a = 32'd3; b = 32'd3; end
          2: flush = 1'b1;
          3: rst = 1'b1;
          4: begin wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5A5A_C3C3; end
          default: ;
        endcase
      end
      tick();
      start = 1'b0; flush = 1'b0; rst = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      a = $urandom; b = $urandom; is_mult = ~m; is_unsigned = ~u;
      if (n == ev_at) begin ev_busy = busy; ev_hi = hi; ev_lo = lo; end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin done_at = n; dz_at_done = div_by_zero; rhi = hi; rlo = lo; end
      end else if (div_by_zero) stray_dz++;
      if (stop_at_done && done) break;
    end
    if (done_at == 0) begin rhi = hi; rlo = lo; end
  endtask

  int d_at, d_cnt, b_cnt, s_dz;
  logic dz, evb;
  logic [W-1:0] rh, rl, eh, el;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_mult = 1'b0; is_unsigned = 1'b0; flush = 1'b0;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF; a = '1; b = '1;
    tick(); tick();
    rst = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
    vectors++; if (hi !== '0) begin miscompares++; $display("FAIL reset_hi got=%h exp=0", hi); end
    vectors++; if (lo !== '0) begin miscompares++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_mult_max();
    run_op(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (rh !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mult_max_hi got=%h exp=fffffffe", rh); end
    vectors++; if (rl !== 32'h0000_0001) begin miscompares++; $display("FAIL mult_max_lo got=%h exp=00000001", rl); end
    vectors++; if (d_at !== LAT) begin miscompares++; $display("FAIL mult_max_latency got=%0d exp=%0d", d_at, LAT); end
    vectors++; if (d_cnt !== 1) begin miscompares++; $display("FAIL mult_max_done_pulses got=%0d exp=1", d_cnt); end
    vectors++; if (b_cnt !== LAT) begin miscompares++; $display("FAIL mult_max_busy_cycles got=%0d exp=%0d", b_cnt, LAT); end
    vectors++; if (dz !== 1'b0 || s_dz !== 0) begin miscompares++; $display("FAIL mult_max_dz got=%b/%0d exp=0/0", dz, s_dz); end
  endtask

  task automatic test_div_start_ignored();
    run_op(0, 0, -32'sd7, 32'd2, 1, 5, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (rl !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg7_lo got=%h exp=fffffffd", rl); end
    vectors++; if (rh !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg7_hi got=%h exp=ffffffff", rh); end
    vectors++; if (d_at !== LAT || d_cnt !== 1) begin miscompares++; $display("FAIL div_neg7_timing got=%0d/%0d exp=%0d/1", d_at, d_cnt, LAT); end
    vectors++; if (b_cnt !== LAT) begin miscompares++; $display("FAIL div_neg7_busy got=%0d exp=%0d", b_cnt, LAT); end
  endtask

  task automatic test_div_by_zero();
    run_op(0, 1, 32'h1234_5678, 32'd0, 0, -1, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (rh !== 32'h1234_5678) begin miscompares++; $display("FAIL dz_hi got=%h exp=12345678", rh); end
    vectors++; if (rl !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dz_lo got=%h exp=ffffffff", rl); end
    vectors++; if (dz !== 1'b1 || s_dz !== 0) begin miscompares++; $display("FAIL dz_flag got=%b/%0d exp=1/0", dz, s_dz); end
    vectors++; if (d_at !== LAT) begin miscompares++; $display("FAIL dz_latency got=%0d exp=%0d", d_at, LAT); end
    run_op(0, 0, 32'h8000_0005, 32'd0, 0, -1, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (rh !== 32'h8000_0005 || rl !== 32'hFFFF_FFFF || dz !== 1'b1) begin
      miscompares++; $display("FAIL dz_signed got=%h/%h/%b exp=80000005/ffffffff/1", rh, rl, dz); end
  endtask

  task automatic test_min_neg1();
    run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (rl !== 32'h8000_0000) begin miscompares++; $display("FAIL min_neg1_lo got=%h exp=80000000", rl); end
    vectors++; if (rh !== 32'h0000_0000) begin miscompares++; $display("FAIL min_neg1_hi got=%h exp=00000000", rh); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL min_neg1_dz got=%b exp=0", dz); end
  endtask

  task automatic test_flush();
    wr_hi = 1'b1; wdata = 32'hAAAA_5555; tick(); wr_hi = 1'b0;
    wr_lo = 1'b1; wdata = 32'h0F0F_0F0F; tick(); wr_lo = 1'b0;
    vectors++; if (hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_0F0F) begin
      miscompares++; $display("FAIL mthi_mtlo got=%h/%h exp=aaaa5555/0f0f0f0f", hi, lo); end
    flush = 1'b1; tick(); flush = 1'b0;
    vectors++; if (busy !== 1'b0 || hi !== 32'hAAAA_5555 || done !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle got=%b/%h/%b exp=0/aaaa5555/0", busy, hi, done); end
    run_op(1, 0, 32'd12345, 32'd678, 2, 10, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (evb !== 1'b0) begin miscompares++; $display("FAIL flush_busy got=%b exp=0", evb); end
    vectors++; if (d_cnt !== 0) begin miscompares++; $display("FAIL flush_done got=%0d exp=0", d_cnt); end
    vectors++; if (rh !== 32'hAAAA_5555 || rl !== 32'h0F0F_0F0F) begin
      miscompares++; $display("FAIL flush_hilo got=%h/%h exp=aaaa5555/0f0f0f0f", rh, rl); end
    // Flush on the FIX edge must block the write and the done pulse.
    run_op(1, 1, 32'd77, 32'd99, 2, LAT, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (d_cnt !== 0 || rh !== 32'hAAAA_5555 || rl !== 32'h0F0F_0F0F) begin
      miscompares++; $display("FAIL flush_fix got=%0d/%h/%h exp=0/aaaa5555/0f0f0f0f", d_cnt, rh, rl); end
  endtask

  task automatic test_writes();
    logic [2*W-1:0] exp;
    logic           edz;
    // A write while busy is ignored; HI/LO still hold the previous values.
    exp = model(1, 1, 32'hCAFE_0001, 32'h0000_BEEF, edz);
    run_op(1, 1, 32'hCAFE_0001, 32'h0000_BEEF, 4, 3, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (eh !== 32'hAAAA_5555 || el !== 32'h0F0F_0F0F) begin
      miscompares++; $display("FAIL wr_busy got=%h/%h exp=aaaa5555/0f0f0f0f", eh, el); end
    vectors++; if ({rh, rl} !== exp) begin miscompares++; $display("FAIL wr_busy_result got=%h%h exp=%h", rh, rl, exp); end
    // A write on the start edge lands at once, and the result overwrites it later.
    exp = model(0, 1, 32'd1000, 32'd7, edz);
    run_op(0, 1, 32'd1000, 32'd7, 4, 0, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (eh !== 32'h5A5A_C3C3 || el !== 32'h5A5A_C3C3 || evb !== 1'b1) begin
      miscompares++; $display("FAIL wr_start_edge got=%h/%h/%b exp=5a5ac3c3/5a5ac3c3/1", eh, el, evb); end
    vectors++; if ({rh, rl} !== exp || d_at !== LAT) begin
      miscompares++; $display("FAIL wr_start_result got=%h%h@%0d exp=%h@%0d", rh, rl, d_at, exp, LAT); end
  endtask

  task automatic test_reset_mid();
    run_op(1, 0, 32'hFFFF_FFFF, 32'd1, 3, 20, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (eh !== '0 || el !== '0 || evb !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid got=%h/%h/%b exp=0/0/0", eh, el, evb); end
    vectors++; if (d_cnt !== 0 || s_dz !== 0) begin miscompares++; $display("FAIL rst_mid_done got=%0d/%0d exp=0/0", d_cnt, s_dz); end
    run_op(1, 0, 32'hFFFF_FFFF, 32'd1, 0, -1, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
    vectors++; if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFFF || d_at !== LAT) begin
      miscompares++; $display("FAIL rst_rerun got=%h/%h@%0d exp=ffffffff/ffffffff@%0d", rh, rl, d_at, LAT); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp;
    logic           edz;
    for (int i = 0; i < 4; i++) begin
      logic         m, u;
      logic [W-1:0] x, y;
      m = i[0]; u = i[1]; x = $urandom; y = $urandom_range(1, 1000);
      exp = model(m, u, x, y, edz);
      // The next start is driven in the done cycle, so it is accepted at once.
      run_op(m, u, x, y, 0, -1, 1, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
      vectors++; if ({rh, rl} !== exp || d_at !== LAT || dz !== edz) begin
        miscompares++; $display("FAIL b2b_%0d got=%h%h@%0d dz=%b exp=%h@%0d dz=%b", i, rh, rl, d_at, dz, exp, LAT, edz); end
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] exp;
    logic           edz;
    for (int i = 0; i < 40; i++) begin
      logic         m, u;
      logic [W-1:0] x, y;
      m = $urandom_range(0, 1); u = $urandom_range(0, 1);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 100); y = $urandom_range(0, 15); end
        3: begin x = -$urandom_range(1, 100); y = $urandom_range(1, 15); end
        4: y = -$urandom_range(1, 9);
        default: ;
      endcase
      exp = model(m, u, x, y, edz);
      run_op(m, u, x, y, 0, -1, 0, d_at, d_cnt, b_cnt, dz, s_dz, rh, rl, evb, eh, el);
      vectors++; if ({rh, rl} !== exp || dz !== edz || d_at !== LAT || d_cnt !== 1) begin
        miscompares++;
        $display("FAIL rand_%0d m=%b u=%b a=%h b=%h got=%h%h dz=%b@%0d exp=%h dz=%b@%0d", i, m, u, x, y, rh, rl, dz, d_at, exp, edz, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_max();
    test_div_start_ignored();
    test_div_by_zero();
    test_min_neg1();
    test_flush();
    test_writes();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iter_mult_div.md
ITER_MULT_DIV -- requirements
Module: iter_mult_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request new operation; accepted only when busy=0.
REQ-005 SHALL have port is_mult  input  1  1=multiply, 0=divide; sampled with start.
REQ-006 SHALL have port is_unsigned  input  1  1=unsigned, 0=two's-complement; sampled with start.
REQ-007 SHALL have ports a, b  input  WIDTH  multiplicand/dividend, multiplier/divisor; sampled with start.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have ports wr_hi, wr_lo  input  1  direct HI/LO write (MTHI/MTLO).
REQ-010 SHALL have port wdata  input  WIDTH  data for wr_hi/wr_lo.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse, HI/LO hold new result.
REQ-013 SHALL have port div_by_zero  output  1  pulses with done when divide had b=0.
REQ-014 SHALL have ports hi, lo  output  WIDTH  registered HI/LO contents.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; busy = (state != IDLE).
REQ-016 IDLE: edge with start=1 SHALL latch operand magnitudes (abs value if signed), result sign flags, load step counter=WIDTH, go to RUN.
REQ-017 RUN SHALL perform exactly one iteration per edge (shift-add multiply, restoring divide, 1 bit/cycle), decrement counter, go to FIX when counter reaches 0.
REQ-018 FIX SHALL apply sign correction, write HI/LO, go to IDLE; done=1 during the following cycle only.
REQ-019 Latency SHALL be fixed: start accepted at edge t0 -> HI/LO updated at edge t0+WIDTH+1, done high in cycle after; busy high WIDTH+1 cycles; no early termination.
REQ-020 Multiply SHALL produce full 2*WIDTH product: HI=upper, LO=lower half; signed product negated when sign(a)!=sign(b).
REQ-021 Divide SHALL produce LO=quotient truncated toward zero, HI=remainder with sign of a.
REQ-022 Divide b=0 SHALL give HI=a, LO=all ones, div_by_zero=1 with done; FSM timing unchanged.
REQ-023 Signed MIN/-1 SHALL give LO=MIN, HI=0, no flag.
REQ-024 start while busy=1 SHALL be ignored (no queueing).
REQ-025 wr_hi/wr_lo while busy=1 SHALL be ignored; in IDLE SHALL update the selected register at the edge; same-edge start also accepted (result later overwrites).
REQ-026 flush in RUN or FIX SHALL return to IDLE at that edge, HI/LO unchanged, no done; flush in IDLE has no effect; flush beats FIX write.
REQ-027 done and div_by_zero SHALL be registered, 0 whenever not pulsing.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, regardless of state or other inputs.
REQ-029 Reset mid-operation SHALL discard the operation with no done pulse.

Structure
REQ-030 Shared package mips_md_pkg SHALL hold the FSM state enum and default WIDTH constant.
REQ-031 One sub-module md_step SHALL hold the combinational single-iteration datapath (mult/div select); FSM, counter, HI/LO and sign fix stay in iter_mult_div.
REQ-032 Product/remainder accumulator SHALL be 2*WIDTH+1 bits; no other widths inferred from WIDTH.

Verification (WIDTH=32)
REQ-033 Unsigned mult 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done 33 edges after start edge plus one cycle.
REQ-034 Signed div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; start pulsed at cycle 5 mid-op ignored, result unchanged.
REQ-035 Divide a=0x12345678, b=0 -> HI=0x12345678, LO=0xFFFFFFFF, div_by_zero=1 same cycle as done.
REQ-036 Signed div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_by_zero=0.
REQ-037 wr_hi 0xAAAA5555 in IDLE, then mult started, flush at cycle 10 -> busy=0 next cycle, no done, HI=0xAAAA5555.
REQ-038 rst asserted at cycle 20 of signed mult -1*1 -> next cycle HI=LO=0, busy=0, done never pulses; rerun without reset -> HI=LO=0xFFFFFFFF.
